// File: rtl/mem_loader.sv
// Byte-stream loader that parses A5-headed frames and writes words into IMEM/DMEM.
// Optional trailing XOR checksum byte is enabled by defining MEM_LOADER_CHECKSUM_EN.
module mem_loader #(
    parameter int WIDTH      = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  cpu_hold,
    output logic                  imem_we,
    output logic                  dmem_we,
    output logic [WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int HW  = (WIDTH > 8) ? WIDTH - 8 : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TARGET,
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHK,
        S_DONE
    } state_t;

    state_t                state_q;
    logic                  target_q;
    logic [HW-1:0]         hi_q;
    logic [WIDTH-1:0]      addr_q;
    logic [WIDTH-1:0]      cnt_q;
    logic [BW-1:0]         byte_q;
    logic [DATA_WIDTH-1:0] word_q;

    logic                  hold_q;
    logic                  imem_we_q;
    logic                  dmem_we_q;
    logic [WIDTH-1:0]      mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  done_q;
    logic                  err_q;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]            chk_q;
    localparam state_t     END_STATE = S_CHK;
`else
    localparam state_t     END_STATE = S_DONE;
`endif

    logic                  accept;
    logic [WIDTH-1:0]      field_d;
    logic [DATA_WIDTH-1:0] word_d;
    logic                  last_byte;

    assign in_ready  = (state_q != S_DONE);
    assign accept    = in_valid & in_ready;
    assign last_byte = (byte_q == BW'(BPW - 1));

    // A 16-bit address/count field keeps only its low WIDTH bits.
    generate
        if (WIDTH > 8) begin : g_wide_field
            assign field_d = {hi_q, in_data};
        end else begin : g_narrow_field
            assign field_d = in_data[WIDTH-1:0];
        end
    endgenerate

    // Word assembler shifts MSB-first; the incoming byte lands in the low lane.
    generate
        if (BPW > 1) begin : g_multi_byte
            assign word_d = {word_q[DATA_WIDTH-9:0], in_data};
        end else begin : g_single_byte
            assign word_d = in_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            target_q    <= 1'b0;
            hi_q        <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            byte_q      <= '0;
            word_q      <= '0;
            hold_q      <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            done_q    <= 1'b0;

            if (state_q == S_DONE) begin
                done_q  <= 1'b1;
                hold_q  <= 1'b0;
                state_q <= S_IDLE;
            end else if (accept) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                if (state_q == S_TARGET) begin
                    chk_q <= in_data;
                end else if (state_q != S_IDLE && state_q != S_CHK) begin
                    chk_q <= chk_q ^ in_data;
                end
`endif
                case (state_q)
                    S_IDLE: begin
                        if (in_data == 8'hA5) begin
                            err_q   <= 1'b0;
                            state_q <= S_TARGET;
                        end
                    end
                    S_TARGET: begin
                        if (in_data[7:1] == 7'd0) begin
                            target_q <= in_data[0];
                            hold_q   <= 1'b1;
                            state_q  <= S_ADDR_HI;
                        end else begin
                            err_q    <= 1'b1;
                            state_q  <= S_IDLE;
                        end
                    end
                    S_ADDR_HI: begin
                        hi_q    <= in_data[HW-1:0];
                        state_q <= S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        addr_q  <= field_d;
                        state_q <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        hi_q    <= in_data[HW-1:0];
                        state_q <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        cnt_q   <= field_d;
                        byte_q  <= '0;
                        state_q <= (field_d == '0) ? END_STATE : S_DATA;
                    end
                    S_DATA: begin
                        word_q <= word_d;
                        if (last_byte) begin
                            byte_q      <= '0;
                            mem_addr_q  <= addr_q;
                            mem_wdata_q <= word_d;
                            imem_we_q   <= ~target_q;
                            dmem_we_q   <= target_q;
                            addr_q      <= addr_q + WIDTH'(1);
                            cnt_q       <= cnt_q - WIDTH'(1);
                            if (cnt_q == WIDTH'(1)) begin
                                state_q <= END_STATE;
                            end
                        end else begin
                            byte_q <= byte_q + BW'(1);
                        end
                    end
`ifdef MEM_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (in_data == chk_q) begin
                            state_q <= S_DONE;
                        end else begin
                            // Bad checksum aborts without a done pulse; issued writes stand.
                            err_q   <= 1'b1;
                            hold_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
`endif
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cpu_hold  = hold_q;
    assign imem_we   = imem_we_q;
    assign dmem_we   = dmem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of frames plus a write scoreboard.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        cpu_hold;
    logic        imem_we;
    logic        dmem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    // {dmem, addr[11:0], data[15:0]}
    logic [28:0] exp_q[$];

    typedef struct {
        logic [95:0] b;     // frame bytes, left-aligned
        int          n;
        int          start; // index of the A5 header
        bit          gaps;
        bit          exp_done;
        bit          exp_err;
        bit          dmem;
        int          nw;
        logic [27:0] w0;    // {addr, data}
        logic [27:0] w1;
    } vec_t;

    vec_t tbl[9];

    mem_loader #(.WIDTH(12), .DATA_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cpu_hold  (cpu_hold),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && (imem_we || dmem_we)) begin
            chk("we_exclusive", {31'd0, imem_we & dmem_we}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h@%0h required=none", mem_wdata, mem_addr);
            end else begin
                logic [28:0] e;
                e = exp_q.pop_front();
                $display("write %s addr=%03h data=%04h", dmem_we ? "DMEM" : "IMEM", mem_addr, mem_wdata);
                chk("wr_target", {31'd0, dmem_we}, {31'd0, e[28]});
                chk("wr_addr",   {20'd0, mem_addr}, {20'd0, e[27:16]});
                chk("wr_data",   {16'd0, mem_wdata}, {16'd0, e[15:0]});
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int w;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 16) begin
            @(negedge clk);
            w++;
        end
        if (w >= 16) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0] bt;
        logic [7:0] cs;
        bit         w_end;
        cs = 8'h00;
        if (v.nw > 0) exp_q.push_back({v.dmem, v.w0});
        if (v.nw > 1) exp_q.push_back({v.dmem, v.w1});
        for (int i = 0; i < v.n; i++) begin
            bt = v.b[95 - 8*i -: 8];
            if (i > v.start) cs = cs ^ bt;
            w_end = !v.exp_err && (i >= v.start + 6) && (((i - v.start - 6) % 2) == 1);
            send_byte(bt, v.gaps);
            if (i == v.start)
                chk("err_cleared_by_header", {31'd0, load_err}, 32'd0);
            if (i == v.start + 1)
                chk("hold_after_target", {31'd0, cpu_hold}, {31'd0, !v.exp_err});
            if (w_end)
                chk("strobe_timing", {31'd0, v.dmem ? dmem_we : imem_we}, 32'd1);
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        if (!v.exp_err) send_byte(cs, v.gaps);
`endif
        chk("hold_before_done", {31'd0, cpu_hold}, {31'd0, !v.exp_err});
        chk("ready_in_done",    {31'd0, in_ready}, {31'd0, !v.exp_done});
        @(negedge clk);
        chk("done_pulse", {31'd0, load_done}, {31'd0, v.exp_done});
        chk("hold_at_done", {31'd0, cpu_hold}, 32'd0);
        chk("err_flag", {31'd0, load_err}, {31'd0, v.exp_err});
        @(negedge clk);
        chk("done_width", {31'd0, load_done}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("frame bytes=%0d done=%0b err=%0b", v.n, v.exp_done, v.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{b:96'hA5_00_00_10_00_02_12_34_AB_CD_00_00, n:10, start:0, gaps:0, exp_done:1, exp_err:0, dmem:0, nw:2, w0:28'h010_1234, w1:28'h011_ABCD};
        tbl[1] = '{b:96'hA5_01_0F_FF_00_02_00_07_00_09_00_00, n:10, start:0, gaps:1, exp_done:1, exp_err:0, dmem:1, nw:2, w0:28'hFFF_0007, w1:28'h000_0009};
        tbl[2] = '{b:96'hA5_02_00_00_00_00_00_00_00_00_00_00, n:2,  start:0, gaps:0, exp_done:0, exp_err:1, dmem:0, nw:0, w0:28'h0, w1:28'h0};
        tbl[3] = '{b:96'hA5_01_00_20_00_01_BE_EF_00_00_00_00, n:8,  start:0, gaps:1, exp_done:1, exp_err:0, dmem:1, nw:1, w0:28'h020_BEEF, w1:28'h0};
        tbl[4] = '{b:96'hA5_00_01_23_00_00_00_00_00_00_00_00, n:6,  start:0, gaps:0, exp_done:1, exp_err:0, dmem:0, nw:0, w0:28'h0, w1:28'h0};
        tbl[5] = '{b:96'h11_A5_00_00_05_00_01_A5_5A_00_00_00, n:9,  start:1, gaps:0, exp_done:1, exp_err:0, dmem:0, nw:1, w0:28'h005_A55A, w1:28'h0};
        tbl[6] = '{b:96'hA5_01_F0_03_F0_01_12_34_00_00_00_00, n:8,  start:0, gaps:0, exp_done:1, exp_err:0, dmem:1, nw:1, w0:28'h003_1234, w1:28'h0};
        tbl[7] = '{b:96'hA5_00_00_00_00_01_56_78_00_00_00_00, n:8,  start:0, gaps:1, exp_done:1, exp_err:0, dmem:0, nw:1, w0:28'h000_5678, w1:28'h0};
        tbl[8] = '{b:96'hA5_00_00_00_00_01_12_34_00_00_00_00, n:8,  start:0, gaps:0, exp_done:1, exp_err:0, dmem:0, nw:1, w0:28'h000_1234, w1:28'h0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_cpu_hold",  {31'd0, cpu_hold},  32'd0);
        chk("rst_imem_we",   {31'd0, imem_we},   32'd0);
        chk("rst_dmem_we",   {31'd0, dmem_we},   32'd0);
        chk("rst_mem_addr",  {20'd0, mem_addr},  32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_load_err",  {31'd0, load_err},  32'd0);
        $display("reset checked");
        @(negedge clk);

        for (int k = 0; k < 7; k++) send_frame(tbl[k]);

        // Reset in the middle of the first data word: nothing written, all idle.
        begin
            logic [47:0] part;
            part = 48'hA5_00_00_00_00_02;
            for (int i = 0; i < 6; i++) send_byte(part[47 - 8*i -: 8], 1'b0);
            send_byte(8'h12, 1'b0);
            chk("mid_hold_before_reset", {31'd0, cpu_hold}, 32'd1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("mid_rst_cpu_hold",  {31'd0, cpu_hold},  32'd0);
            chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
            chk("mid_rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
            chk("mid_rst_mem_addr",  {20'd0, mem_addr},  32'd0);
            $display("mid-frame reset applied");
        end
        send_frame(tbl[7]);
        send_frame(tbl[8]);

`ifdef MEM_LOADER_CHECKSUM_EN
        // Bad checksum: write stands, no done pulse, error set, hold dropped.
        begin
            logic [63:0] fr;
            fr = 64'hA5_00_00_00_00_01_12_34;
            exp_q.push_back({1'b0, 28'h000_1234});
            for (int i = 0; i < 8; i++) begin
                send_byte(fr[63 - 8*i -: 8], 1'b0);
                if (i == 7) chk("chk_bad_strobe", {31'd0, imem_we}, 32'd1);
            end
            send_byte(8'h00, 1'b0);
            chk("chk_bad_err",  {31'd0, load_err},  32'd1);
            chk("chk_bad_hold", {31'd0, cpu_hold},  32'd0);
            @(negedge clk);
            chk("chk_bad_no_done", {31'd0, load_done}, 32'd0);
            chk("chk_bad_sb_empty", exp_q.size(), 32'd0);
            $display("bad checksum frame sent");
        end
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
